// File: rtl/fixed_float_pkg.sv
// Shared types and helpers for the fixed-point to IEEE-754 single conversion pipeline.
//   FLOAT_BIAS   : single-precision exponent bias
//   float32_t    : {sign, exp, mant} view of a 32-bit float
//   lead_one_idx : index of the most significant set bit of a 32-bit word (0 if none)
package fixed_float_pkg;

  localparam logic [7:0] FLOAT_BIAS = 8'd127;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float32_t;

  function automatic logic [4:0] lead_one_idx(input logic [31:0] vec);
    logic [4:0] idx;
    idx = '0;
    // Ascending scan so the highest set bit wins.
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lead_one_detect.sv
// Priority encoder: position of the most significant set bit of vec.
//   vec   : input word, W bits (W <= 32)
//   idx   : index of the leading one (0 when vec is zero)
//   found : vec has at least one bit set
module lead_one_detect
  import fixed_float_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] vec,
  output logic [4:0]   idx,
  output logic         found
);

  assign idx   = lead_one_idx(32'(vec));
  assign found = |vec;

endmodule

// File: rtl/fixed_to_float_pipe.sv
// Three-stage fixed-point to IEEE-754 single-precision converter with valid/ready flow control.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_valid, o_ready  : input handshake; i_fixed is taken when both are high
//   i_fixed           : IN_W-bit sample, value = i_fixed * 2^-FRAC_W
//   o_valid, i_ready  : output handshake; o_float is retired when both are high
//   o_float           : {sign, exp[7:0], mant[22:0]}
// Stages: S1 sign/magnitude, S2 leading-one normalise, S3 round and pack (output register).
module fixed_to_float_pipe
  import fixed_float_pkg::*;
#(
  parameter int unsigned IN_W     = 16,
  parameter int unsigned FRAC_W   = 0,
  parameter bit          SIGNED   = 1'b1,
  parameter bit          ROUND_NE = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [IN_W-1:0] i_fixed,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_float
);

  localparam int unsigned PadW = 32 - IN_W;

  if (IN_W < 2 || IN_W > 32) begin : g_bad_in_w
    $error("fixed_to_float_pipe: IN_W must be in 2..32");
  end
  if (FRAC_W > IN_W - 1) begin : g_bad_frac_w
    $error("fixed_to_float_pipe: FRAC_W must be in 0..IN_W-1");
  end

  logic            s1_valid, s1_sign;
  logic [IN_W-1:0] s1_mag;
  logic            s2_valid, s2_sign, s2_zero;
  logic [4:0]      s2_p;
  logic [IN_W-1:0] s2_norm;

  // Enable chain: a stage loads when empty or when its successor loads.
  logic en1, en2, en3;
  assign en3     = !o_valid || i_ready;
  assign en2     = !s2_valid || en3;
  assign en1     = !s1_valid || en2;
  assign o_ready = en1;

  // S1: sign and magnitude. Negation wraps in IN_W bits, so the most negative
  // input lands on 2^(IN_W-1), which is the correct unsigned magnitude.
  logic            in_neg;
  logic [IN_W-1:0] in_mag;
  assign in_neg = SIGNED && i_fixed[IN_W-1];
  assign in_mag = in_neg ? ((~i_fixed) + IN_W'(1)) : i_fixed;

  // S2: leading-one detect and left-normalise.
  logic [4:0]      lod_idx;
  logic            lod_found;
  logic [4:0]      norm_sh;
  logic [IN_W-1:0] norm_word;

  lead_one_detect #(
    .W (IN_W)
  ) u_lod (
    .vec   (s1_mag),
    .idx   (lod_idx),
    .found (lod_found)
  );

  assign norm_sh   = 5'(IN_W - 1) - lod_idx;
  assign norm_word = s1_mag << norm_sh;

  // S3: round and pack. The normalised word is left-aligned in 32 bits so the
  // leading one is always bit 31; mantissa is [30:8], guard/round/sticky below.
  // When p <= 23 the low byte is all zero, so no rounding happens there.
  logic [31:0] ext;
  logic [22:0] mant_raw;
  logic        guard, rnd, sticky, round_up;
  logic [23:0] mant_sum;
  float32_t    packed_f;

  always_comb begin
    ext      = 32'(s2_norm) << PadW;
    mant_raw = ext[30:8];
    guard    = ext[7];
    rnd      = ext[6];
    sticky   = |ext[5:0];
    round_up = ROUND_NE && guard && (rnd || sticky || mant_raw[0]);
    mant_sum = {1'b0, mant_raw} + 24'(round_up);
    // A carry out leaves mant_sum[22:0] at zero, so only the exponent needs bumping.
    packed_f.sign = s2_sign;
    packed_f.exp  = FLOAT_BIAS + 8'(s2_p) - 8'(FRAC_W) + 8'(mant_sum[23]);
    packed_f.mant = mant_sum[22:0];
    if (s2_zero) packed_f = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b1;
      s2_p     <= '0;
      s2_norm  <= '0;
      o_valid  <= 1'b0;
      o_float  <= '0;
    end else begin
      if (en1) begin
        s1_valid <= i_valid;
        if (i_valid) begin
          s1_sign <= in_neg;
          s1_mag  <= in_mag;
        end
      end
      if (en2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_sign <= s1_sign && lod_found;
          s2_zero <= !lod_found;
          s2_p    <= lod_idx;
          s2_norm <= norm_word;
        end
      end
      if (en3) begin
        o_valid <= s2_valid;
        if (s2_valid) o_float <= packed_f;
      end
    end
  end

endmodule

// File: tb/tb_fixed_to_float_pipe.sv
// Scoreboard bench for fixed_to_float_pipe: four instances covering the 16-bit integer,
// 16-bit Q8 and 32-bit RNE/truncate configurations. Drivers push expected floats on
// transfer; a monitor pops and compares on every output transfer.
module tb_fixed_to_float_pipe;

  typedef struct {
    logic [31:0] val;
    int          cyc;
    bit          chk;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iv  [4];
  logic        ir  [4];
  logic        rdy [4];
  logic        ov  [4];
  logic [31:0] fx  [4];
  logic [31:0] of  [4];

  item_t       sb_q [4][$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          stalled [4];
  logic [31:0] held [4];
  int          out_cnt [4];
  bit          saw_not_ready = 0;

  logic [31:0] stream_exp [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fixed_to_float_pipe #(.IN_W(16), .FRAC_W(0), .SIGNED(1'b1), .ROUND_NE(1'b1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv[0]), .o_ready(rdy[0]), .i_fixed(fx[0][15:0]),
    .o_valid(ov[0]), .i_ready(ir[0]), .o_float(of[0]));
  fixed_to_float_pipe #(.IN_W(16), .FRAC_W(8), .SIGNED(1'b1), .ROUND_NE(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv[1]), .o_ready(rdy[1]), .i_fixed(fx[1][15:0]),
    .o_valid(ov[1]), .i_ready(ir[1]), .o_float(of[1]));
  fixed_to_float_pipe #(.IN_W(32), .FRAC_W(0), .SIGNED(1'b1), .ROUND_NE(1'b1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv[2]), .o_ready(rdy[2]), .i_fixed(fx[2]),
    .o_valid(ov[2]), .i_ready(ir[2]), .o_float(of[2]));
  fixed_to_float_pipe #(.IN_W(32), .FRAC_W(0), .SIGNED(1'b1), .ROUND_NE(1'b0)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_valid(iv[3]), .o_ready(rdy[3]), .i_fixed(fx[3]),
    .o_valid(ov[3]), .i_ready(ir[3]), .o_float(of[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic send(input int k, input logic [31:0] v, input logic [31:0] e, input bit chk);
    int    n = 0;
    item_t it;
    @(negedge clk);
    iv[k] = 1'b1;
    fx[k] = v;
    #1;
    while (!rdy[k] && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rdy[k]) begin
      total++;
      bad++;
      $display("FAIL send_timeout dut%0d: got ready=0 want ready=1", k);
      iv[k] = 1'b0;
      return;
    end
    it.val = e;
    it.cyc = cyc;
    it.chk = chk;
    sb_q[k].push_back(it);
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size()) != 0 &&
           n < 200) begin
      @(negedge clk);
      n++;
    end
    if ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size()) != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0",
               sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: samples mid-cycle, after drivers and the ready pattern have settled.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 4; k++) begin
        if (rst) begin
          stalled[k] = 1'b0;
        end else begin
          if (stalled[k]) begin
            check($sformatf("stall_valid_dut%0d", k), 32'(ov[k]), 32'd1);
            check($sformatf("stall_hold_dut%0d", k), of[k], held[k]);
          end
          if (k == 0 && !rdy[0]) saw_not_ready = 1'b1;
          if (ov[k] && ir[k]) begin
            check($sformatf("ready_on_retire_dut%0d", k), 32'(rdy[k]), 32'd1);
            if (sb_q[k].size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_out_dut%0d: got %h want no output", k, of[k]);
            end else begin
              it = sb_q[k].pop_front();
              check($sformatf("out_dut%0d", k), of[k], it.val);
              out_cnt[k]++;
              if (it.chk) check($sformatf("latency_dut%0d", k), 32'(cyc - it.cyc), 32'd3);
            end
            stalled[k] = 1'b0;
          end else if (ov[k]) begin
            stalled[k] = 1'b1;
            held[k]    = of[k];
          end else begin
            stalled[k] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int base;
    for (int k = 0; k < 4; k++) begin
      iv[k]      = 1'b0;
      ir[k]      = 1'b1;
      fx[k]      = '0;
      stalled[k] = 1'b0;
      held[k]    = '0;
      out_cnt[k] = 0;
    end
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_o_valid", 32'(ov[0]), 32'd0);
    check("rst_o_float", of[0], 32'h0);
    rst = 1'b0;
    #1;
    check("rst_o_ready", 32'(rdy[0]), 32'd1);

    // Integer 16-bit, idle pipeline: check exact latency too.
    send(0, 32'h0001, 32'h3F800000, 1'b1);
    drain();
    send(0, 32'h4000, 32'h46800000, 1'b1);
    send(0, 32'h8000, 32'hC7000000, 1'b0);
    send(0, 32'h0000, 32'h00000000, 1'b0);
    send(0, 32'hFFFF, 32'hBF800000, 1'b0);
    send(0, 32'h7FFF, 32'h46FFFE00, 1'b0);
    // Q8.8
    send(1, 32'h0180, 32'h3FC00000, 1'b1);
    send(1, 32'hFE80, 32'hBFC00000, 1'b0);
    send(1, 32'h0001, 32'h3B800000, 1'b0);
    // 32-bit rounding
    send(2, 32'h01000001, 32'h4B800000, 1'b1);
    send(2, 32'h01000003, 32'h4B800002, 1'b0);
    send(2, 32'h01FFFFFF, 32'h4C000000, 1'b0);
    send(2, 32'h80000000, 32'hCF000000, 1'b0);
    send(3, 32'h01FFFFFF, 32'h4BFFFFFF, 1'b0);
    send(3, 32'h01000003, 32'h4B800001, 1'b0);
    drain();

    // Back-to-back stream with downstream stalled for cycles 2..6.
    base          = out_cnt[0];
    saw_not_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(0, 32'(i), stream_exp[i-1], 1'b0);
      end
      begin
        for (int c = 0; c < 12; c++) begin
          @(negedge clk);
          ir[0] = !(c >= 2 && c <= 6);
        end
        ir[0] = 1'b1;
      end
    join
    drain();
    check("stream_count", 32'(out_cnt[0] - base), 32'd8);
    check("ready_dropped", 32'(saw_not_ready), 32'd1);

    // Reset with two samples in flight, one already presented at the output.
    send(0, 32'h0009, 32'h41100000, 1'b0);
    send(0, 32'h000A, 32'h41200000, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(ov[0]), 32'd1);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) sb_q[k].delete();
    #1;
    check("async_rst_valid", 32'(ov[0]), 32'd0);
    check("async_rst_float", of[0], 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(rdy[0]), 32'd1);
    send(0, 32'hFFFE, 32'hC0000000, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
